// File: rtl/par_to_ser_multi.sv
// Multi-lane parallel-to-serial shifter with SDR/DDR, bitslip framing and PRBS7 test words.
// A word accepted at a load edge is on ser_rise/ser_fall one cycle later; par_ready is high one cycle in SLOTS, and underruns send IDLE_WORD.
module par_to_ser_multi #(
  parameter int                  CHANNELS  = 3,
  parameter int                  WORD_W    = 10,
  parameter int                  DDR       = 1,
  parameter int                  MSB_FIRST = 0,
  parameter int unsigned         IDLE_WORD = 32'h354,
  parameter logic [CHANNELS-1:0] INVERT    = '0
) (
  input  logic                         clk_ser,
  input  logic                         rst,
  input  logic [CHANNELS*WORD_W-1:0]   par_data,
  input  logic                         par_valid,
  output logic                         par_ready,
  input  logic [CHANNELS-1:0]          bitslip,
  input  logic                         prbs_en,
  output logic [CHANNELS-1:0]          ser_rise,
  output logic [CHANNELS-1:0]          ser_fall,
  output logic                         frame_start,
  output logic                         underrun,
  output logic [15:0]                  underrun_cnt
);

  localparam int BPC    = (DDR != 0) ? 2 : 1;
  localparam int SLOTS  = WORD_W / BPC;
  localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int ROT_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);
  localparam logic [ROT_W-1:0]  LAST_ROT  = ROT_W'(WORD_W - 1);
  localparam logic [WORD_W-1:0] IDLE_W    = IDLE_WORD[WORD_W-1:0];

  logic [SLOT_W-1:0]                slot_q, slot_d;
  logic [CHANNELS-1:0][WORD_W-1:0]  sr_q, sr_d;
  logic [CHANNELS-1:0][ROT_W-1:0]   rot_q, rot_d;
  logic [6:0]                       lfsr_q, lfsr_d;
  logic                             underrun_q, underrun_d;
  logic [15:0]                      underrun_cnt_q, underrun_cnt_d;
  logic                             frame_start_q, frame_start_d;

  logic                             load;
  logic [6:0]                       lfsr_v;
  logic                             prbs_bit;
  logic [WORD_W-1:0]                prbs_word;
  logic [WORD_W-1:0]                src_word;
  logic [WORD_W-1:0]                ord_word;
  logic [2*WORD_W-1:0]              rot_dbl;

  always_comb begin
    load           = (slot_q == LAST_SLOT);
    slot_d         = load ? '0 : slot_q + 1'b1;
    lfsr_v         = lfsr_q;
    prbs_bit       = 1'b0;
    prbs_word      = '0;
    src_word       = '0;
    ord_word       = '0;
    rot_dbl        = '0;
    sr_d           = sr_q;
    rot_d          = rot_q;

    // Generated bit i becomes word bit i, so word[0] is the oldest PRBS bit.
    for (int i = 0; i < WORD_W; i++) begin
      prbs_bit     = lfsr_v[6] ^ lfsr_v[5];
      prbs_word[i] = prbs_bit;
      lfsr_v       = {lfsr_v[5:0], prbs_bit};
    end
    lfsr_d = (load && prbs_en) ? lfsr_v : lfsr_q;

    for (int c = 0; c < CHANNELS; c++) begin
      if (prbs_en) begin
        src_word = prbs_word;
      end else if (par_valid) begin
        src_word = par_data[c*WORD_W +: WORD_W];
      end else begin
        src_word = IDLE_W;
      end
      ord_word = src_word;
      if (MSB_FIRST != 0) begin
        for (int i = 0; i < WORD_W; i++) begin
          ord_word[i] = src_word[WORD_W-1-i];
        end
      end
      // Each slip delays the lane's framing by one bit time: bit i is sent at time i+rot.
      rot_dbl  = {ord_word, ord_word} << rot_q[c];
      sr_d[c]  = load ? rot_dbl[2*WORD_W-1 -: WORD_W] : (sr_q[c] >> BPC);
      if (bitslip[c]) begin
        rot_d[c] = (rot_q[c] == LAST_ROT) ? '0 : rot_q[c] + 1'b1;
      end
    end

    underrun_d     = load && !prbs_en && !par_valid;
    underrun_cnt_d = (underrun_d && (underrun_cnt_q != 16'hFFFF)) ? underrun_cnt_q + 16'd1
                                                                  : underrun_cnt_q;
    frame_start_d  = load;
  end

  always_ff @(posedge clk_ser or posedge rst) begin
    if (rst) begin
      slot_q         <= LAST_SLOT;
      sr_q           <= '0;
      rot_q          <= '0;
      lfsr_q         <= 7'h7F;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= '0;
      frame_start_q  <= 1'b0;
    end else begin
      slot_q         <= slot_d;
      sr_q           <= sr_d;
      rot_q          <= rot_d;
      lfsr_q         <= lfsr_d;
      underrun_q     <= underrun_d;
      underrun_cnt_q <= underrun_cnt_d;
      frame_start_q  <= frame_start_d;
    end
  end

  always_comb begin
    ser_rise = '0;
    ser_fall = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      ser_rise[c] = sr_q[c][0]     ^ INVERT[c];
      ser_fall[c] = sr_q[c][BPC-1] ^ INVERT[c];
    end
  end

  assign par_ready    = load;
  assign frame_start  = frame_start_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = underrun_cnt_q;

endmodule
